// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the 16-point FFT input stage.
// Imported by s_p, s_p_bank and s_p_if.
// bitrev4 is used only when S_P_BITREV_EN is defined.
package fft_pkg;

  localparam int DATA_W  = 34;
  localparam int N_POINT = 16;
  localparam int LANES   = 4;
  localparam int IDX_W   = 4;

  // Index of the last sample in a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINT - 1);

  // One 4-lane parallel beat, lane 0 in the LSBs.
  typedef logic [LANES*DATA_W-1:0] beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction

endpackage

// File: rtl/s_p_if.sv
// s_p_if: serial sample input and 4-lane beat output of the FFT input stage.
// slave modport faces the s_p block; master modport faces the upstream/downstream side.
// No ready signals: the downstream core always accepts.
interface s_p_if;
  import fft_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              in_sof;
  beat_t             data_out;
  logic              out_valid;
  logic [1:0]        beat_idx;
  logic              frame_start;
  logic              align_err;

  modport master (
    output data_in, in_valid, in_sof,
    input  data_out, out_valid, beat_idx, frame_start, align_err
  );

  modport slave (
    input  data_in, in_valid, in_sof,
    output data_out, out_valid, beat_idx, frame_start, align_err
  );

endinterface

// File: rtl/s_p_bank.sv
// s_p_bank: 16-entry sample store with indexed write and a 4-lane beat gather.
// Latency: write lands at the clock edge; gather read is combinational.
// Backpressure: none; a write happens whenever wr_en is high.
// S_P_BITREV_EN defined: beat b gathers four consecutive entries 4b..4b+3
// (the writer stores bit-reversed); undefined: beat b gathers stride-4 entries.
module s_p_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [1:0]        rd_beat,
  output beat_t             rd_dat
);

  logic [DATA_W-1:0] mem [N_POINT];

  // Sample storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Gather the four lanes that make up the requested beat.
  always_comb begin
    rd_dat = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef S_P_BITREV_EN
      rd_dat[DATA_W*l +: DATA_W] = mem[{rd_beat, 2'(l)}];
`else
      rd_dat[DATA_W*l +: DATA_W] = mem[{2'(l), rd_beat}];
`endif
    end
  end

endmodule

// File: rtl/s_p.sv
// s_p: serial-to-parallel FFT input stage; ping-pong banks, 4 beats of 4 lanes per frame.
// Latency: first beat registered 1 cycle after the 16th sample; beats on 4 consecutive cycles.
// Backpressure: none; in_valid low stalls the writer, the read side never stalls.
// S_P_BITREV_EN: when defined, samples are stored at bit-reversed indices (DIT order).
module s_p
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  s_p_if.slave bus
);

  logic [IDX_W-1:0] wr_cnt;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_addr;
  logic             sof_mid;
  logic             frame_done;

  rd_state_t        state, state_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [1:0]       rd_beat, rd_beat_nxt;
  logic             beat_vld;

  beat_t            bank0_rd, bank1_rd, gather;

  // A start-of-frame mid-frame throws away the partial frame and restarts at index 0.
  assign sof_mid    = bus.in_valid & bus.in_sof & (wr_cnt != '0);
  assign wr_idx     = sof_mid ? '0 : wr_cnt;
  assign frame_done = bus.in_valid & (wr_idx == LAST_IDX);

`ifdef S_P_BITREV_EN
  assign wr_addr = bitrev4(wr_idx);
`else
  assign wr_addr = wr_idx;
`endif

  s_p_bank u_bank0 (
    .clk     (clk),
    .wr_en   (bus.in_valid & ~wr_bank),
    .wr_addr (wr_addr),
    .wr_dat  (bus.data_in),
    .rd_beat (rd_beat),
    .rd_dat  (bank0_rd)
  );

  s_p_bank u_bank1 (
    .clk     (clk),
    .wr_en   (bus.in_valid & wr_bank),
    .wr_addr (wr_addr),
    .wr_dat  (bus.data_in),
    .rd_beat (rd_beat),
    .rd_dat  (bank1_rd)
  );

  assign gather = rd_bank ? bank1_rd : bank0_rd;

  // Write counter and bank select; the 4-bit counter wraps 15 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (bus.in_valid) begin
      wr_cnt <= wr_idx + 1'b1;
      if (frame_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_beat <= 2'd0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      rd_beat <= rd_beat_nxt;
    end
  end

  // Read FSM next state: step through 4 beats; a completed frame always re-arms on its bank.
  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    rd_beat_nxt = rd_beat;
    beat_vld    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      READ: begin
        beat_vld = 1'b1;
        if (rd_beat == 2'd3) begin
          state_nxt = IDLE;
        end else begin
          rd_beat_nxt = rd_beat + 2'd1;
        end
      end
    endcase
    if (frame_done) begin
      state_nxt   = READ;
      rd_bank_nxt = wr_bank;
      rd_beat_nxt = 2'd0;
    end
  end

  // Registered outputs; data_out holds its last beat while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data_out    <= '0;
      bus.out_valid   <= 1'b0;
      bus.beat_idx    <= 2'd0;
      bus.frame_start <= 1'b0;
      bus.align_err   <= 1'b0;
    end else begin
      bus.out_valid   <= beat_vld;
      bus.beat_idx    <= beat_vld ? rd_beat : 2'd0;
      bus.frame_start <= beat_vld & (rd_beat == 2'd0);
      if (beat_vld) begin
        bus.data_out <= gather;
      end
      if (sof_mid) begin
        bus.align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s_p.sv
// tb_s_p: randomized self-checking bench for s_p against a frame-level reference model.
// Honours S_P_BITREV_EN for the expected lane order.
module tb_s_p;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  s_p_if bus();

  s_p dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    beat_t dat;
    int    idx;
    bit    fs;
    int    edge_n;
  } beat_rec_t;

  beat_rec_t obs_q[$];
  beat_rec_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples of the current frame, count, expected sticky error.
  logic [DATA_W-1:0] m_cur [16];
  int                m_cnt = 0;
  bit                m_err = 1'b0;

  // Record every beat the DUT presents.
  always @(negedge clk) begin
    beat_rec_t r;
    if (bus.out_valid === 1'b1) begin
      r.dat    = bus.data_out;
      r.idx    = int'(bus.beat_idx);
      r.fs     = bus.frame_start;
      r.edge_n = cyc;
      obs_q.push_back(r);
    end
  end

  function automatic int tb_rev(input int p);
    return ((p & 1) << 3) | ((p & 2) << 1) | ((p & 4) >> 1) | ((p & 8) >> 3);
  endfunction

  // Frame-level model: collect 16 samples, then expect 4 beats starting 1 edge later.
  task automatic model_push(input logic [DATA_W-1:0] x, input bit sof, input int cap_edge);
    beat_rec_t r;
    int src;
    if (sof && m_cnt != 0) begin
      m_cnt = 0;
      m_err = 1'b1;
    end
    m_cur[m_cnt] = x;
    m_cnt++;
    if (m_cnt == 16) begin
      for (int b = 0; b < 4; b++) begin
        r.dat = '0;
        for (int l = 0; l < 4; l++) begin
`ifdef S_P_BITREV_EN
          src = tb_rev(4 * b + l);
`else
          src = 4 * l + b;
`endif
          r.dat[DATA_W*l +: DATA_W] = m_cur[src];
        end
        r.idx    = b;
        r.fs     = (b == 0);
        r.edge_n = cap_edge + 1 + b;
        exp_q.push_back(r);
      end
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input bit sof, input bit vld);
    @(negedge clk);
    bus.data_in  = x;
    bus.in_sof   = sof;
    bus.in_valid = vld;
    if (vld) model_push(x, sof, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_sample();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic test_reset();
    bus.data_in  = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.data_out !== '0) begin
      n_fail++; $display("FAIL reset_data_out: got %h, expected 0", bus.data_out);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.beat_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_beat_idx: got %0d, expected 0", bus.beat_idx);
    end
    n_checks++;
    if (bus.frame_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_start: got %b, expected 0", bus.frame_start);
    end
    n_checks++;
    if (bus.align_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_align_err: got %b, expected 0", bus.align_err);
    end
    rst_n = 1'b1;
    m_cnt = 0;
    m_err = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_basic();
    beat_t last;
    logic [DATA_W-1:0] lane1_exp;
    for (int n = 0; n < 16; n++) send(DATA_W'(n), n == 0, 1'b1);
    idle(8);
`ifdef S_P_BITREV_EN
    lane1_exp = DATA_W'(8);
`else
    lane1_exp = DATA_W'(4);
`endif
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0].dat[DATA_W +: DATA_W] !== lane1_exp) begin
        n_fail++; $display("FAIL basic_beat0_lane1: got %0d, expected %0d",
                           obs_q[0].dat[DATA_W +: DATA_W], lane1_exp);
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ({obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n} !==
          {exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got dat=%h idx=%0d fs=%0b edge=%0d, expected dat=%h idx=%0d fs=%0b edge=%0d",
                 i, obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n,
                 exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n);
      end
    end
    last = (exp_q.size() > 0) ? exp_q[$].dat : '0;
    n_checks++;
    if ({bus.out_valid, bus.beat_idx, bus.frame_start, bus.align_err} !== 5'b0) begin
      n_fail++; $display("FAIL basic_idle_ctrl: got vld=%b idx=%0d fs=%b err=%b, expected all 0",
                         bus.out_valid, bus.beat_idx, bus.frame_start, bus.align_err);
    end
    n_checks++;
    if (bus.data_out !== last) begin
      n_fail++; $display("FAIL basic_idle_hold: got %h, expected %h", bus.data_out, last);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) send(DATA_W'(n), 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) send(DATA_W'(100 + n), 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) send(rnd_sample(), 1'b0, 1'b1);
    idle(8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ({obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n} !==
          {exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n}) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got dat=%h idx=%0d fs=%0b edge=%0d, expected dat=%h idx=%0d fs=%0b edge=%0d",
                 i, obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n,
                 exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_gapped();
    for (int n = 0; n < 16; n++) begin
      send(DATA_W'(n), 1'b0, 1'b1);
      send('0, 1'b0, 1'b0);
    end
    for (int n = 0; n < 16; n++) begin
      send(rnd_sample(), 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) send(rnd_sample(), 1'b0, 1'b0);
    end
    idle(8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL gap_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ({obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n} !==
          {exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n}) begin
        n_fail++;
        $display("FAIL gap_beat%0d: got dat=%h idx=%0d fs=%0b edge=%0d, expected dat=%h idx=%0d fs=%0b edge=%0d",
                 i, obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n,
                 exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_sof_realign();
    for (int n = 0; n < 7; n++) send(rnd_sample(), n == 0, 1'b1);
    for (int n = 0; n < 16; n++) send(DATA_W'(200 + n), n == 0, 1'b1);
    idle(6);
    n_checks++;
    if (bus.align_err !== 1'b1) begin
      n_fail++; $display("FAIL sof_align_err: got %b, expected 1", bus.align_err);
    end
    for (int n = 0; n < 16; n++) send(rnd_sample(), 1'b0, 1'b1);
    idle(8);
    n_checks++;
    if (bus.align_err !== 1'b1) begin
      n_fail++; $display("FAIL sof_align_err_sticky: got %b, expected 1", bus.align_err);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sof_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ({obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n} !==
          {exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n}) begin
        n_fail++;
        $display("FAIL sof_beat%0d: got dat=%h idx=%0d fs=%0b edge=%0d, expected dat=%h idx=%0d fs=%0b edge=%0d",
                 i, obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n,
                 exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_readout();
    bit found = 1'b0;
    int lim;
    for (int n = 0; n < 16; n++) send(DATA_W'(300 + n), 1'b0, 1'b1);
    send(DATA_W'(400), 1'b0, 1'b1);
    send(DATA_W'(401), 1'b0, 1'b1);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      if (bus.out_valid === 1'b1 && bus.beat_idx === 2'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rstmid_wait_beat2: got no beat 2 within 40 cycles, expected one");
    end
    rst_n = 1'b0;
    lim = cyc + 1;
    while (exp_q.size() > 0 && exp_q[$].edge_n >= lim) void'(exp_q.pop_back());
    m_cnt = 0;
    m_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.beat_idx, bus.frame_start, bus.align_err} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got vld=%b idx=%0d fs=%b err=%b, expected all 0",
                         bus.out_valid, bus.beat_idx, bus.frame_start, bus.align_err);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) send(rnd_sample(), 1'b0, 1'b1);
    idle(8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ({obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n} !==
          {exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n}) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d: got dat=%h idx=%0d fs=%0b edge=%0d, expected dat=%h idx=%0d fs=%0b edge=%0d",
                 i, obs_q[i].dat, obs_q[i].idx, obs_q[i].fs, obs_q[i].edge_n,
                 exp_q[i].dat, exp_q[i].idx, exp_q[i].fs, exp_q[i].edge_n);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_sof_realign();
    test_reset_mid_readout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
